rr_grant_scheduler: RTL and testbench

Round-robin scheduler that shares one downstream resource among N requesters using a one-hot rotating priority pointer. The pointer is the team's ring-counter structure. It resets to requester 0 and advances past each served requester, so no requester starves. A hold-time limit forcibly reclaims the resource from an owner that never releases it. The block sits between requester front-ends and any single shared datapath (bus, ALU, memory port).

---
 rtl/rr_grant_scheduler_pkg.sv | 21 ++
 rtl/rr_grant_scheduler_pick.sv | 17 +
 rtl/rr_grant_scheduler.sv | 101 ++++++++++
 tb/tb_rr_grant_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  // One-hot rotate-left by one within the low n bits; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    mask  = (MAX_N'(1) << n) - MAX_N'(1);
    rotl1 = ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic int onehot2bin(input logic [MAX_N-1:0] v);
    onehot2bin = 0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) onehot2bin = i;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// Masked priority search: first set req bit at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         vld
);
  logic [N-1:0] upper, src;

  // ptr is one-hot, so ~(ptr-1) covers ptr and every bit above it.
  assign upper = req & ~(ptr - N'(1));
  assign src   = (|upper) ? upper : req;
  assign pick  = src & (~src + N'(1));
  assign vld   = |req;
endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler with rotating one-hot pointer and hold-time limit.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);
  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d, ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]     pick;
  logic             pick_vld;
  logic [MAX_N-1:0] rot_full;
  logic             own_req, own_done, release_now;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .vld  (pick_vld)
  );

  assign own_req  = |(req & gnt_q);
  assign own_done = |(done & gnt_q);
  assign rot_full = rotl1(MAX_N'(gnt_q), N);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick;
          gnt_id_d = IDW'(onehot2bin(MAX_N'(pick)));
          hold_d   = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Normal release wins over the hold limit when both occur together.
        if (own_done || !own_req) begin
          release_now = 1'b1;
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else if (hold_q < HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
        if (release_now) begin
          gnt_d   = '0;
          ptr_d   = rot_full[N-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      hold_q    <= '0;
      ptr_q     <= N'(1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench: directed vector table, corner sequences, random vs reference model.
module tb_rr_grant_scheduler;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, done, gnt;
  logic [1:0]   gnt_id;
  logic         busy, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: owner index (-1 = none), pointer index, cycles the owner has held.
  int   m_owner, m_ptr, m_held;
  logic m_to;

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic [N-1:0] g;
  } vec_t;
  vec_t tbl[$];

  rr_grant_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    bit found;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && r[idx]) begin
          found = 1; m_owner = idx; m_held = 1;
        end
      end
    end else if (d[m_owner] || !r[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else if (m_held == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] eg;
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_busy", 32'(busy), 32'(m_owner >= 0));
    chk("model_timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] g);
    vec_t v;
    v.r = r; v.d = d; v.g = g;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; req = '0; done = '0;
    model_reset();
    #2;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    chk("reset_gnt_id", 32'(gnt_id), 32'h0);
    #10 reset = 1'b0;

    // Basic grant/release, then ptr moved past 0 so bit 3 beats bit 0.
    add(4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0001, 4'b0000);
    add(4'b1001, 4'b0000, 4'b1000);
    add(4'b1001, 4'b1000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000);
    // All requesting, each owner releases after 2 cycles: strict rotation with gaps.
    for (int k = 0; k < N; k++) begin
      add(4'b1111, 4'b0000, 4'(1 << k));
      add(4'b1111, 4'b0000, 4'(1 << k));
      add(4'b1111, 4'(1 << k), 4'b0000);
    end
    add(4'b1111, 4'b0000, 4'b0001);
    add(4'b1111, 4'b0001, 4'b0000);
    // Non-owner done bits are ignored; owner dropping req releases.
    add(4'b0100, 4'b0000, 4'b0100);
    add(4'b0100, 4'b0001, 4'b0100);
    add(4'b0100, 4'b1011, 4'b0100);
    add(4'b0000, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|tbl[i].g));
    end

    // Hold limit: sole requester keeps gnt for exactly MAX_HOLD cycles.
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0001, 4'b0000);
      chk("hold_gnt", 32'(gnt), 32'h1);
      chk("hold_to_low", 32'(timeout), 32'h0);
    end
    step(4'b0001, 4'b0000);
    chk("forced_gnt", 32'(gnt), 32'h0);
    chk("forced_to", 32'(timeout), 32'h1);
    step(4'b0001, 4'b0000);
    chk("regrant_sole", 32'(gnt), 32'h1);
    chk("to_one_cycle", 32'(timeout), 32'h0);
    // Same again with a competitor: after forced release requester 1 wins.
    for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0011, 4'b0000);
    chk("hold2_gnt", 32'(gnt), 32'h1);
    step(4'b0011, 4'b0000);
    chk("forced2_to", 32'(timeout), 32'h1);
    step(4'b0011, 4'b0000);
    chk("after_forced_pick", 32'(gnt), 32'h2);
    step(4'b0000, 4'b0000);
    chk("drop_release", 32'(gnt), 32'h0);

    // done on the last permitted cycle is a normal release.
    step(4'b0001, 4'b0000);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0001, 4'b0000);
    chk("cyc8_gnt", 32'(gnt), 32'h1);
    step(4'b0001, 4'b0001);
    chk("cyc8_release", 32'(gnt), 32'h0);
    chk("cyc8_no_to", 32'(timeout), 32'h0);
    step(4'b0000, 4'b0000);

    // Asynchronous reset mid-grant, then ptr restarts at bit 0.
    step(4'b0100, 4'b0000);
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_id", 32'(gnt_id), 32'h0);
    chk("async_rst_to", 32'(timeout), 32'h0);
    model_reset();
    #2 reset = 1'b0;
    step(4'b1100, 4'b0000);
    chk("post_rst_gnt", 32'(gnt), 32'h4);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r, d;
      r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      d = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(r, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
